// File: rtl/mult_accum_pkg.sv
// Shared types and default widths for the multiply-accumulate stage.
// Optional feature: MAC_SATURATE_EN (saturating accumulation).
package mult_accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned PROD_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 16;
  localparam int unsigned CNT_W_DEF  = 4;

endpackage

// File: rtl/mult_accum_stage_if.sv
// Control, product stream and result stream of the multiply-accumulate stage.
// The master side drives commands and products; the slave side is the stage.
interface mult_accum_stage_if #(
  parameter int unsigned PROD_W = mult_accum_pkg::PROD_W_DEF,
  parameter int unsigned ACC_W  = mult_accum_pkg::ACC_W_DEF,
  parameter int unsigned CNT_W  = mult_accum_pkg::CNT_W_DEF
);

  logic              start_i;
  logic [CNT_W-1:0]  len_i;
  logic              clear_i;
  logic [PROD_W-1:0] prod_i;
  logic              prod_valid_i;
  logic              prod_ready_o;
  logic [ACC_W-1:0]  acc_o;
  logic              acc_valid_o;
  logic              acc_ready_i;
  logic              busy_o;
  logic              ovf_o;

  modport master (
    output start_i, len_i, clear_i, prod_i, prod_valid_i, acc_ready_i,
    input  prod_ready_o, acc_o, acc_valid_o, busy_o, ovf_o
  );

  modport slave (
    input  start_i, len_i, clear_i, prod_i, prod_valid_i, acc_ready_i,
    output prod_ready_o, acc_o, acc_valid_o, busy_o, ovf_o
  );

endinterface

// File: rtl/mult_accum_add.sv
// Accumulator adder: zero-extended product plus accumulator, with carry out.
// With MAC_SATURATE_EN defined a carry clamps the sum to all ones.
module mult_accum_add #(
  parameter int unsigned PROD_W = mult_accum_pkg::PROD_W_DEF,
  parameter int unsigned ACC_W  = mult_accum_pkg::ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full;

  // One extra bit captures the carry out of the accumulator width.
  always_comb begin
    full  = {1'b0, acc} + (ACC_W+1)'(prod);
    carry = full[ACC_W];
`ifdef MAC_SATURATE_EN
    sum   = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    sum   = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mult_accum_stage.sv
// Multiply-accumulate stage: sums a burst of products into a wide accumulator
// and holds the result on a valid/ready output until taken.
// Optional feature: MAC_SATURATE_EN (saturate instead of wrap on overflow).
module mult_accum_stage
  import mult_accum_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  mult_accum_stage_if.slave bus
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;
  logic               prod_ready;
  logic               beat;

  mult_accum_add #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc  (acc_q),
    .prod (bus.prod_i),
    .sum  (add_sum),
    .carry(add_carry)
  );

  // Handshake qualifiers; clear suppresses acceptance of any offered beat.
  always_comb begin
    prod_ready = (state_q == RUN) && !bus.clear_i;
    beat       = prod_ready && bus.prod_valid_i;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update; clear overrides everything.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (bus.clear_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
            if (bus.len_i == '0) begin
              state_d = DONE;
            end else begin
              cnt_d   = bus.len_i;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (beat) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_carry;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          // start in the exit cycle is dropped: only registered IDLE honours it
          if (bus.acc_ready_i) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output drive.
  always_comb begin
    bus.prod_ready_o = prod_ready;
    bus.acc_o        = acc_q;
    bus.acc_valid_o  = (state_q == DONE);
    bus.busy_o       = (state_q != IDLE);
    bus.ovf_o        = ovf_q;
  end

endmodule

// File: tb/tb_mult_accum_stage.sv
// Self-checking bench for mult_accum_stage: a 16-bit and an 8-bit accumulator
// instance driven in lockstep, compared against a sum-of-products model.
// Honours MAC_SATURATE_EN for the expected overflow behaviour.
module tb_mult_accum_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, clear, prod_valid, acc_ready;
  logic [3:0] len;
  logic [7:0] prod;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_accum_stage_if #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) bus16 ();
  mult_accum_stage_if #(.PROD_W(8), .ACC_W(8),  .CNT_W(4)) bus8 ();

  assign bus16.start_i      = start;
  assign bus16.len_i        = len;
  assign bus16.clear_i      = clear;
  assign bus16.prod_i       = prod;
  assign bus16.prod_valid_i = prod_valid;
  assign bus16.acc_ready_i  = acc_ready;
  assign bus8.start_i       = start;
  assign bus8.len_i         = len;
  assign bus8.clear_i       = clear;
  assign bus8.prod_i        = prod;
  assign bus8.prod_valid_i  = prod_valid;
  assign bus8.acc_ready_i   = acc_ready;

  mult_accum_stage #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus16)
  );

  mult_accum_stage #(.PROD_W(8), .ACC_W(8), .CNT_W(4)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  // Expected 8-bit result for a burst whose true sum is total.
  function automatic logic [7:0] model8(input int unsigned total);
`ifdef MAC_SATURATE_EN
    return (total > 255) ? 8'hFF : total[7:0];
`else
    return total[7:0];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic take_result();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({bus16.acc_o, bus16.acc_valid_o, bus16.busy_o, bus16.ovf_o, bus16.prod_ready_o} !== 20'h0) begin
      n_err++;
      $display("FAIL reset16: outputs=%h expected 0",
               {bus16.acc_o, bus16.acc_valid_o, bus16.busy_o, bus16.ovf_o, bus16.prod_ready_o});
    end
    rst_n = 1'b1;
    tick();
    start_burst(4'd5);
    prod_valid = 1'b1;
    prod = 8'd50;
    tick();
    tick();
    n_cmp++;
    if (bus16.busy_o !== 1'b1 || bus16.acc_o !== 16'd100) begin
      n_err++;
      $display("FAIL reset_midrun_pre: busy=%b acc=%0d expected busy=1 acc=100",
               bus16.busy_o, bus16.acc_o);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus16.acc_o, bus16.acc_valid_o, bus16.busy_o, bus16.ovf_o, bus16.prod_ready_o} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_async16: outputs=%h expected 0",
               {bus16.acc_o, bus16.acc_valid_o, bus16.busy_o, bus16.ovf_o, bus16.prod_ready_o});
    end
    n_cmp++;
    if ({bus8.acc_o, bus8.acc_valid_o, bus8.busy_o, bus8.ovf_o, bus8.prod_ready_o} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_async8: outputs=%h expected 0",
               {bus8.acc_o, bus8.acc_valid_o, bus8.busy_o, bus8.ovf_o, bus8.prod_ready_o});
    end
    prod_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_burst();
    start_burst(4'd3);
    n_cmp++;
    if (bus16.prod_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL burst_ready: prod_ready=%b expected 1", bus16.prod_ready_o);
    end
    prod_valid = 1'b1;
    prod = 8'd6;
    tick();
    prod = 8'd15;
    tick();
    n_cmp++;
    if (bus16.acc_valid_o !== 1'b0 || bus16.acc_o !== 16'd21) begin
      n_err++;
      $display("FAIL burst_partial: valid=%b acc=%0d expected valid=0 acc=21",
               bus16.acc_valid_o, bus16.acc_o);
    end
    prod = 8'd225;
    tick();
    prod_valid = 1'b0;
    n_cmp++;
    if (bus16.acc_valid_o !== 1'b1 || bus16.acc_o !== 16'd246 || bus16.ovf_o !== 1'b0) begin
      n_err++;
      $display("FAIL burst_result: valid=%b acc=%0d ovf=%b expected 1/246/0",
               bus16.acc_valid_o, bus16.acc_o, bus16.ovf_o);
    end
    take_result();
    n_cmp++;
    if (bus16.busy_o !== 1'b0 || bus16.acc_valid_o !== 1'b0 || bus16.acc_o !== 16'd246) begin
      n_err++;
      $display("FAIL burst_exit: busy=%b valid=%b acc=%0d expected 0/0/246",
               bus16.busy_o, bus16.acc_valid_o, bus16.acc_o);
    end
  endtask

  task automatic test_bubbles();
    logic       v[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] p[4] = '{8'd10, 8'd99, 8'd98, 8'd20};
    start_burst(4'd2);
    for (int i = 0; i < 4; i++) begin
      prod_valid = v[i];
      prod = p[i];
      tick();
    end
    prod_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus16.acc_valid_o !== 1'b1 || bus16.acc_o !== 16'd30) begin
        n_err++;
        $display("FAIL bubble_hold[%0d]: valid=%b acc=%0d expected 1/30",
                 i, bus16.acc_valid_o, bus16.acc_o);
      end
      tick();
    end
    // start offered in the exit cycle must be dropped
    acc_ready = 1'b1;
    start = 1'b1;
    len = 4'd3;
    tick();
    acc_ready = 1'b0;
    start = 1'b0;
    n_cmp++;
    if (bus16.busy_o !== 1'b0 || bus16.acc_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL bubble_exit: busy=%b valid=%b expected 0/0",
               bus16.busy_o, bus16.acc_valid_o);
    end
  endtask

  task automatic test_empty();
    start_burst(4'd0);
    n_cmp++;
    if (bus16.acc_valid_o !== 1'b1 || bus16.acc_o !== 16'd0 || bus16.busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL empty: valid=%b acc=%0d busy=%b expected 1/0/1",
               bus16.acc_valid_o, bus16.acc_o, bus16.busy_o);
    end
    take_result();
  endtask

  task automatic test_overflow();
    logic [7:0] exp8;
    exp8 = model8(300);
    start_burst(4'd2);
    prod_valid = 1'b1;
    prod = 8'd200;
    tick();
    prod = 8'd100;
    tick();
    prod_valid = 1'b0;
    n_cmp++;
    if (bus8.acc_o !== exp8 || bus8.ovf_o !== 1'b1 || bus8.acc_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL ovf8: acc=%0d ovf=%b valid=%b expected %0d/1/1",
               bus8.acc_o, bus8.ovf_o, bus8.acc_valid_o, exp8);
    end
    n_cmp++;
    if (bus16.acc_o !== 16'd300 || bus16.ovf_o !== 1'b0) begin
      n_err++;
      $display("FAIL ovf16: acc=%0d ovf=%b expected 300/0", bus16.acc_o, bus16.ovf_o);
    end
    take_result();
    n_cmp++;
    if (bus8.ovf_o !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: ovf=%b expected 1", bus8.ovf_o);
    end
    start_burst(4'd1);
    n_cmp++;
    if (bus8.ovf_o !== 1'b0 || bus8.acc_o !== 8'd0) begin
      n_err++;
      $display("FAIL ovf_restart: ovf=%b acc=%0d expected 0/0", bus8.ovf_o, bus8.acc_o);
    end
    prod_valid = 1'b1;
    prod = 8'd5;
    tick();
    prod_valid = 1'b0;
    n_cmp++;
    if (bus8.acc_o !== 8'd5 || bus8.ovf_o !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_next: acc=%0d ovf=%b expected 5/0", bus8.acc_o, bus8.ovf_o);
    end
    take_result();
  endtask

  task automatic test_abort();
    start_burst(4'd4);
    prod_valid = 1'b1;
    prod = 8'd40;
    tick();
    prod = 8'd77;
    clear = 1'b1;
    #1;
    n_cmp++;
    if (bus16.prod_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL abort_ready: prod_ready=%b expected 0", bus16.prod_ready_o);
    end
    tick();
    clear = 1'b0;
    prod_valid = 1'b0;
    n_cmp++;
    if (bus16.busy_o !== 1'b0 || bus16.acc_o !== 16'd0 || bus16.ovf_o !== 1'b0 ||
        bus16.acc_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: busy=%b acc=%0d ovf=%b valid=%b expected 0/0/0/0",
               bus16.busy_o, bus16.acc_o, bus16.ovf_o, bus16.acc_valid_o);
    end
    start_burst(4'd2);
    prod_valid = 1'b1;
    prod = 8'd3;
    tick();
    prod = 8'd4;
    tick();
    prod_valid = 1'b0;
    n_cmp++;
    if (bus16.acc_valid_o !== 1'b1 || bus16.acc_o !== 16'd7) begin
      n_err++;
      $display("FAIL abort_restart: valid=%b acc=%0d expected 1/7",
               bus16.acc_valid_o, bus16.acc_o);
    end
    take_result();
  endtask

  task automatic test_random();
    int unsigned total;
    int          l, got, cycles, w;
    logic        v;
    logic [7:0]  p;
    for (int b = 0; b < 40; b++) begin
      l = $urandom_range(0, 15);
      start_burst(l[3:0]);
      total = 0;
      got = 0;
      cycles = 0;
      while (got < l && cycles < 200) begin
        v = ($urandom_range(0, 3) != 0);
        p = 8'($urandom);
        prod_valid = v;
        prod = p;
        n_cmp++;
        if (bus16.prod_ready_o !== 1'b1) begin
          n_err++;
          $display("FAIL rand_ready[%0d]: prod_ready=%b expected 1", b, bus16.prod_ready_o);
        end
        if (v && bus16.prod_ready_o === 1'b1) begin
          total += p;
          got++;
        end
        tick();
        cycles++;
      end
      prod_valid = 1'b0;
      if (cycles >= 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL rand_timeout[%0d]: accepted %0d expected %0d", b, got, l);
      end
      w = $urandom_range(0, 3);
      for (int i = 0; i <= w; i++) begin
        n_cmp++;
        if (bus16.acc_valid_o !== 1'b1 || bus16.acc_o !== 16'(total) || bus16.ovf_o !== 1'b0) begin
          n_err++;
          $display("FAIL rand16[%0d]: valid=%b acc=%0d ovf=%b expected 1/%0d/0",
                   b, bus16.acc_valid_o, bus16.acc_o, bus16.ovf_o, total);
        end
        n_cmp++;
        if (bus8.acc_o !== model8(total) || bus8.ovf_o !== (total > 255)) begin
          n_err++;
          $display("FAIL rand8[%0d]: acc=%0d ovf=%b expected %0d/%b",
                   b, bus8.acc_o, bus8.ovf_o, model8(total), (total > 255));
        end
        if (i < w) tick();
      end
      take_result();
      n_cmp++;
      if (bus16.busy_o !== 1'b0) begin
        n_err++;
        $display("FAIL rand_exit[%0d]: busy=%b expected 0", b, bus16.busy_o);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    prod_valid = 1'b0;
    acc_ready = 1'b0;
    len = 4'd0;
    prod = 8'd0;
    test_reset();
    test_burst();
    test_bubbles();
    test_empty();
    test_overflow();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
